mem_port_arbiter: RTL

- Shares one single-port memory between the core's instruction-fetch path and its load/store path.
- Grants one requester at a time and sequences a req/ack transaction to memory.
- Returns read data and an ack pulse to the granted requester.
- Generates the core stall signal and a bus-error flag on memory timeout.
- Sits between the core datapath (fetch and lw/sw ports) and the unified memory.

---
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction
// fetch port and the load/store port. One requester is served at a time.
//
// Handshake: every port uses a hold-until-ack scheme. The requester raises
// req with stable address/data and keeps it high until a one-cycle ack. On
// the memory side mem_req and mem_* stay stable until mem_ack. An ack is
// only meaningful while the matching req is high. mem_ack seen outside a
// BUSY state is ignored.
module mem_port_arbiter #(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT         = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          bus_err,
  output logic          core_stall
);

  localparam logic     TIMEOUT_EN = (TIMEOUT != 0);
  localparam int       TW = TIMEOUT_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam int       SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_EN ? TIMEOUT - 1 : 0);
  localparam logic [TW-1:0] TIMER_SAT  = '1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2,
    DONE    = 2'd3
  } state_t;

  // state is kept as a named signal so checkers can bind to it directly
  state_t        state;
  state_t        state_next;
  logic [SW-1:0] streak;
  logic [TW-1:0] timer;
  logic          grant_d;
  logic          grant_if;
  logic          finish;
  logic          timed_out;
  logic          busy;

  assign busy       = (state == BUSY_IF) || (state == BUSY_D);
  assign core_stall = (if_req & ~if_ack) | (d_req & ~d_ack);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state, arbitration decision and transaction completion
  always_comb begin
    state_next = state;
    grant_d    = 1'b0;
    grant_if   = 1'b0;
    finish     = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        // data wins unless fetch is waiting and data already had its streak
        if (d_req && (!if_req || (streak < STREAK_MAX))) begin
          grant_d    = 1'b1;
          state_next = BUSY_D;
        end else if (if_req) begin
          grant_if   = 1'b1;
          state_next = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_D: begin
        // a real ack beats a timeout landing on the same cycle
        if (mem_ack) begin
          finish     = 1'b1;
          state_next = DONE;
        end else if (TIMEOUT_EN && (timer == TIMER_LAST)) begin
          finish     = 1'b1;
          timed_out  = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory-side request registers, starvation streak, timeout timer, acks
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      bus_err   <= 1'b0;
      streak    <= '0;
      timer     <= '0;
    end else begin
      if_ack  <= 1'b0;
      d_ack   <= 1'b0;
      bus_err <= 1'b0;

      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        if (!if_req)                  streak <= '0;
        else if (streak != STREAK_MAX) streak <= streak + 1'b1;
      end

      if (grant_if) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        streak    <= '0;
      end

      if (busy) begin
        if (timer != TIMER_SAT) timer <= timer + 1'b1;
      end else begin
        timer <= '0;
      end

      if (finish) begin
        mem_req <= 1'b0;
        bus_err <= timed_out;
        if (state == BUSY_IF) begin
          if_ack   <= 1'b1;
          if_rdata <= timed_out ? '0 : mem_rdata;
        end else begin
          d_ack   <= 1'b1;
          d_rdata <= (timed_out || mem_we) ? '0 : mem_rdata;
        end
      end
    end
  end

endmodule
